// File: rtl/csr_bank.sv
// rtl/csr_bank.sv - parametrised CSR bank with valid/ready access, range errors and optional IRQ unit
// Optional interrupt unit (IRQ_STAT/IRQ_MASK, edge capture, irq) is compiled in with CSR_BANK_IRQ_EN.
module csr_bank #(
   parameter int REG_W      = 8,
   parameter int ADDR_W     = 8,
   parameter int NUM_CFG    = 8,
   parameter int NUM_STATUS = 8,
   parameter int NUM_IRQ    = 4,
   parameter logic [NUM_CFG*REG_W-1:0] CFG_RST = '0
) (
   input  logic                        clk,
   input  logic                        rstb,
   input  logic                        ena,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        wr_rdn,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [REG_W-1:0]            wdata,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [REG_W-1:0]            rdata,
   output logic                        err,
   output logic [NUM_CFG*REG_W-1:0]    rw_regs,
   input  logic [NUM_STATUS*REG_W-1:0] ro_regs,
   input  logic [NUM_IRQ-1:0]          irq_src,
   output logic                        irq
);

   logic [NUM_CFG-1:0][REG_W-1:0] cfg_q;
   logic                          region;
   logic [31:0]                   idx;
   logic                          cfg_hit, ro_hit, stat_hit, mask_hit;
   logic                          accept, req_err;
   logic [REG_W-1:0]              rd, stat_w, mask_w;
   logic                          rsp_valid_q, err_q;
   logic [REG_W-1:0]              rdata_q;

   assign region  = addr[ADDR_W-1];
   assign idx     = 32'(addr[ADDR_W-2:0]);
   assign cfg_hit = !region && (idx < 32'(NUM_CFG));
   assign ro_hit  = region && (idx < 32'(NUM_STATUS));

   assign req_ready = ena && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign req_err   = !(cfg_hit || ro_hit || stat_hit || mask_hit) || (wr_rdn && ro_hit);

`ifdef CSR_BANK_IRQ_EN
   logic [NUM_IRQ-1:0] src_q, stat_q, mask_q, rise, clr;
   logic               irq_q;

   assign stat_hit = region && (idx == 32'(NUM_STATUS));
   assign mask_hit = region && (idx == 32'(NUM_STATUS + 1));
   assign rise     = irq_src & ~src_q;
   assign clr      = (accept && wr_rdn && stat_hit) ? wdata[NUM_IRQ-1:0] : '0;

   always_comb begin
      stat_w = '0;
      mask_w = '0;
      stat_w[NUM_IRQ-1:0] = stat_q;
      mask_w[NUM_IRQ-1:0] = mask_q;
   end

   // Set is OR-ed in after the clear so a same-cycle edge wins over W1C.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         src_q  <= '0;
         stat_q <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         src_q  <= irq_src;
         stat_q <= (stat_q & ~clr) | rise;
         if (accept && wr_rdn && mask_hit)
            mask_q <= wdata[NUM_IRQ-1:0];
         irq_q  <= |(stat_q & mask_q);
      end
   end

   assign irq = irq_q;
`else
   logic unused_irq_src;

   assign unused_irq_src = ^irq_src;
   assign stat_hit       = 1'b0;
   assign mask_hit       = 1'b0;
   assign stat_w         = '0;
   assign mask_w         = '0;
   assign irq            = 1'b0;
`endif

   always_comb begin
      rd = '0;
      for (int i = 0; i < NUM_CFG; i++)
         if (cfg_hit && idx == 32'(i))
            rd = cfg_q[i];
      for (int i = 0; i < NUM_STATUS; i++)
         if (ro_hit && idx == 32'(i))
            rd = ro_regs[i*REG_W +: REG_W];
      if (stat_hit)
         rd = stat_w;
      if (mask_hit)
         rd = mask_w;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cfg_q <= CFG_RST;
      end else if (accept && wr_rdn && cfg_hit) begin
         for (int i = 0; i < NUM_CFG; i++)
            if (idx == 32'(i))
               cfg_q[i] <= wdata;
      end
   end

   // Response payload only changes on acceptance, so it holds while stalled.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         err_q       <= req_err;
         rdata_q     <= (wr_rdn || req_err) ? '0 : rd;
      end else if (rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rdata     = rdata_q;
   assign err       = err_q;
   assign rw_regs   = cfg_q;

endmodule

// File: tb/tb_csr_bank.sv
// tb/tb_csr_bank.sv - scoreboard bench for csr_bank; IRQ checks follow CSR_BANK_IRQ_EN
module tb_csr_bank;
   localparam logic [63:0] CFG_RST = 64'h0007060504030201;

   logic        clk = 1'b0;
   logic        rstb, ena, req_valid, req_ready, wr_rdn, rsp_valid, rsp_ready, err, irq;
   logic [7:0]  addr, wdata, rdata;
   logic [63:0] rw_regs, ro_regs;
   logic [3:0]  irq_src;

   int          tests = 0;
   int          fails = 0;
   logic [8:0]  exp_q[$];
   logic [8:0]  mon_e;

   always #5 clk = ~clk;

   csr_bank #(
      .REG_W(8), .ADDR_W(8), .NUM_CFG(8), .NUM_STATUS(8), .NUM_IRQ(4), .CFG_RST(CFG_RST)
   ) dut (
      .clk(clk), .rstb(rstb), .ena(ena), .req_valid(req_valid), .req_ready(req_ready),
      .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rdata(rdata), .err(err), .rw_regs(rw_regs),
      .ro_regs(ro_regs), .irq_src(irq_src), .irq(irq)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops one expected response per completed response handshake.
   always @(negedge clk) begin
      if (rstb && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got rdata %0h err %0b with empty scoreboard", rdata, err);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_rdata", rdata, mon_e[7:0]);
            check("rsp_err", err, mon_e[8]);
         end
      end
   end

   task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] e_rdata, input logic e_err);
      int n = 0;
      #1;
      req_valid = 1'b1;
      wr_rdn    = w;
      addr      = a;
      wdata     = d;
      #1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         tests++;
         fails++;
         $display("FAIL req_timeout: addr %0h not accepted, required acceptance", a);
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back({e_err, e_rdata});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("rsp_latency", rsp_valid, 1'b1);
   endtask

   initial begin
      int n;
      rstb = 1'b0; ena = 1'b1; req_valid = 1'b0; wr_rdn = 1'b0; addr = '0; wdata = '0;
      rsp_ready = 1'b1; irq_src = '0; ro_regs = 64'h99003C0000000000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rdata", rdata, 8'h00);
      check("rst_err", err, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_rw_regs", rw_regs, CFG_RST);
      @(negedge clk);
      rstb = 1'b1;
      @(posedge clk);

      do_req(1'b0, 8'h02, 8'h00, 8'h03, 1'b0);
      do_req(1'b1, 8'h03, 8'hA5, 8'h00, 1'b0);
      check("rw_regs_byte3", rw_regs[31:24], 8'hA5);
      do_req(1'b0, 8'h03, 8'h00, 8'hA5, 1'b0);
      do_req(1'b0, 8'h07, 8'h00, 8'h00, 1'b0);
      do_req(1'b0, 8'h85, 8'h00, 8'h3C, 1'b0);
      do_req(1'b1, 8'h85, 8'h11, 8'h00, 1'b1);
      check("ro_write_no_change", rw_regs, 64'h00070605A5030201);
      do_req(1'b0, 8'h85, 8'h00, 8'h3C, 1'b0);
      do_req(1'b0, 8'h87, 8'h00, 8'h99, 1'b0);
      do_req(1'b0, 8'h0A, 8'h00, 8'h00, 1'b1);
      do_req(1'b0, 8'h8A, 8'h00, 8'h00, 1'b1);
      do_req(1'b1, 8'hFF, 8'h55, 8'h00, 1'b1);

      // Stall the response for three cycles, then release with a request waiting.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      do_req(1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
      repeat (3) begin
         check("hold_req_ready", req_ready, 1'b0);
         check("hold_rsp_valid", rsp_valid, 1'b1);
         check("hold_rdata", rdata, 8'h01);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      check("release_req_ready", req_ready, 1'b1);
      do_req(1'b0, 8'h01, 8'h00, 8'h02, 1'b0);

      @(posedge clk); #1;
      ena = 1'b0;
      #1;
      check("ena_low_req_ready", req_ready, 1'b0);
      ena = 1'b1;

`ifdef CSR_BANK_IRQ_EN
      do_req(1'b1, 8'h89, 8'hFF, 8'h00, 1'b0);
      do_req(1'b0, 8'h89, 8'h00, 8'h0F, 1'b0);
      do_req(1'b1, 8'h89, 8'h04, 8'h00, 1'b0);
      irq_src = 4'b0100;
      @(posedge clk); #1;
      irq_src = 4'b0000;
      check("irq_one_cycle", irq, 1'b0);
      @(posedge clk); #1;
      check("irq_two_cycles", irq, 1'b1);
      do_req(1'b0, 8'h88, 8'h00, 8'h04, 1'b0);
      do_req(1'b1, 8'h88, 8'h04, 8'h00, 1'b0);
      @(posedge clk); #1;
      check("irq_cleared", irq, 1'b0);
      do_req(1'b0, 8'h88, 8'h00, 8'h00, 1'b0);
      irq_src = 4'b0100;
      @(posedge clk); #1;
      irq_src = 4'b0000;
      @(posedge clk); #1;
      irq_src = 4'b0100;
      do_req(1'b1, 8'h88, 8'h04, 8'h00, 1'b0);
      irq_src = 4'b0000;
      do_req(1'b0, 8'h88, 8'h00, 8'h04, 1'b0);
      check("irq_set_wins", irq, 1'b1);
`else
      do_req(1'b0, 8'h88, 8'h00, 8'h00, 1'b1);
      do_req(1'b1, 8'h89, 8'h04, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) begin
         irq_src = (i % 2 == 0) ? 4'hF : 4'h0;
         @(posedge clk); #1;
         check("irq_disabled", irq, 1'b0);
      end
`endif

      // Reset in the middle of a pending response.
      do_req(1'b1, 8'h05, 8'h77, 8'h00, 1'b0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      do_req(1'b0, 8'h05, 8'h00, 8'h77, 1'b0);
      #2;
      rstb = 1'b0;
      #1;
      check("midrst_rsp_valid", rsp_valid, 1'b0);
      check("midrst_rw_regs", rw_regs, CFG_RST);
      check("midrst_irq", irq, 1'b0);
      exp_q.delete();
      @(negedge clk);
      rstb = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      do_req(1'b0, 8'h05, 8'h00, 8'h06, 1'b0);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("scoreboard_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
